// File: rtl/triumph_imem_if.sv
// Fetch and loader signal bundle between the Triumph core side and triumph_imem.
// The memory is the slave; the core/loader side is the master.
interface triumph_imem_if #(
  parameter int MEM_WORDS = 1024
);
  logic [31:0]                  instr_addr_i;
  logic [31:0]                  instr_rdata_o;
  logic                         instr_rvalid_o;
  logic                         load_valid_i;
  logic                         load_ready_o;
  logic [7:0]                   load_data_i;
  logic                         load_last_i;
  logic                         load_busy_o;
  logic                         load_err_o;
  logic [$clog2(MEM_WORDS):0]   load_count_o;

  modport master (
    output instr_addr_i,
    input  instr_rdata_o,
    input  instr_rvalid_o,
    output load_valid_i,
    input  load_ready_o,
    output load_data_i,
    output load_last_i,
    input  load_busy_o,
    input  load_err_o,
    input  load_count_o
  );

  modport slave (
    input  instr_addr_i,
    output instr_rdata_o,
    output instr_rvalid_o,
    input  load_valid_i,
    output load_ready_o,
    input  load_data_i,
    input  load_last_i,
    output load_busy_o,
    output load_err_o,
    output load_count_o
  );
endinterface

// File: rtl/triumph_imem.sv
// Instruction memory for the Triumph core: registered 1-cycle fetch port plus a
// little-endian byte-stream loader that fills the array from word 0 upward.
module triumph_imem #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic           clk_i,
  input  logic           rst_i,
  triumph_imem_if.slave  bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PTR_MAX = CW'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_reg;
  logic [1:0]      cnt_reg;
  logic [31:0]     asm_reg;
  logic [CW-1:0]   ptr_reg;
  logic            last_seen_reg;
  logic            ready_reg;
  logic            busy_reg;
  logic            err_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     rdata_reg;
  logic            rvalid_reg;

  logic [31:0]     mem [MEM_WORDS];

  logic [AW-1:0]   rd_idx;
  logic            rd_oor;
  logic            accept;
  logic            wr_en;
  logic            unused_addr_lsb;

  // Byte offset within the word plays no part in a word fetch.
  assign unused_addr_lsb = ^bus.instr_addr_i[1:0];

  assign rd_idx = bus.instr_addr_i[AW+1:2];
  assign rd_oor = |bus.instr_addr_i[31:AW+2];
  assign accept = bus.load_valid_i && ready_reg;
  assign wr_en  = (state_reg == WRITE) && (ptr_reg < PTR_MAX);

  // Array has no reset so it maps onto block RAM; contents survive a core reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[ptr_reg[AW-1:0]] <= asm_reg;
    end
  end

  // Read-before-write: a same-cycle write to the fetched word returns old data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      rdata_reg  <= rd_oor ? NOP_WORD : mem[rd_idx];
      rvalid_reg <= (state_reg == IDLE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      asm_reg       <= '0;
      ptr_reg       <= '0;
      last_seen_reg <= 1'b0;
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            asm_reg       <= {24'b0, bus.load_data_i};
            cnt_reg       <= 2'd1;
            ptr_reg       <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            last_seen_reg <= bus.load_last_i;
            busy_reg      <= 1'b1;
            if (bus.load_last_i) begin
              state_reg <= WRITE;
              ready_reg <= 1'b0;
            end else begin
              state_reg <= FILL;
            end
          end
        end

        FILL: begin
          if (accept) begin
            asm_reg[{cnt_reg, 3'b000} +: 8] <= bus.load_data_i;
            cnt_reg       <= cnt_reg + 2'd1;
            last_seen_reg <= bus.load_last_i;
            if ((cnt_reg == 2'd3) || bus.load_last_i) begin
              state_reg <= WRITE;
              ready_reg <= 1'b0;
            end
          end
        end

        WRITE: begin
          // Past the end of the array the word is dropped, never wrapped.
          if (ptr_reg < PTR_MAX) begin
            count_reg <= count_reg + CW'(1);
          end else begin
            err_reg <= 1'b1;
          end
          if (ptr_reg != PTR_MAX) begin
            ptr_reg <= ptr_reg + CW'(1);
          end
          asm_reg   <= '0;
          cnt_reg   <= 2'd0;
          ready_reg <= 1'b1;
          if (last_seen_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= FILL;
          end
        end

        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_rdata_o  = rdata_reg;
  assign bus.instr_rvalid_o = rvalid_reg;
  assign bus.load_ready_o   = ready_reg;
  assign bus.load_busy_o    = busy_reg;
  assign bus.load_err_o     = err_reg;
  assign bus.load_count_o   = count_reg;
endmodule

// File: tb/tb_triumph_imem.sv
// Bench for triumph_imem: a default-size and a 4-word instance share the same
// stimulus; fetch results are scoreboarded against a shadow memory model.
module tb_triumph_imem;
  localparam int          BIG   = 1024;
  localparam int          SMALL = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  triumph_imem_if #(.MEM_WORDS(BIG))   bus ();
  triumph_imem_if #(.MEM_WORDS(SMALL)) sbus ();

  assign sbus.instr_addr_i = bus.instr_addr_i;
  assign sbus.load_valid_i = bus.load_valid_i;
  assign sbus.load_data_i  = bus.load_data_i;
  assign sbus.load_last_i  = bus.load_last_i;

  triumph_imem #(.MEM_WORDS(BIG)) dut_big (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  triumph_imem #(.MEM_WORDS(SMALL)) dut_small (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (sbus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_big   [BIG];
  bit          k_big   [BIG];
  logic [31:0] m_small [SMALL];
  bit          k_small [SMALL];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] eb;
    bit          cb;
    logic [31:0] es;
    bit          cs;
  } sb_t;

  sb_t         sb_q[$];
  logic [7:0]  img[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdata"},  bus.instr_rdata_o, 32'h0);
    check({tag, "_rvalid"}, 32'(bus.instr_rvalid_o), 32'h0);
    check({tag, "_ready"},  32'(bus.load_ready_o), 32'h1);
    check({tag, "_busy"},   32'(bus.load_busy_o), 32'h0);
    check({tag, "_err"},    32'(bus.load_err_o), 32'h0);
    check({tag, "_count"},  32'(bus.load_count_o), 32'h0);
    $display("reset %s: rdata=%h busy=%0b count=%0d", tag, bus.instr_rdata_o,
             bus.load_busy_o, bus.load_count_o);
  endtask

  task automatic predict(input logic [31:0] a, output sb_t e);
    e.addr = a;
    if (|a[31:12]) begin
      e.eb = NOP; e.cb = 1'b1;
    end else begin
      e.eb = m_big[a[11:2]]; e.cb = k_big[a[11:2]];
    end
    if (|a[31:4]) begin
      e.es = NOP; e.cs = 1'b1;
    end else begin
      e.es = m_small[a[3:2]]; e.cs = k_small[a[3:2]];
    end
  endtask

  // Drive one fetch address; the registered word is compared one edge later.
  task automatic fetch(input logic [31:0] a);
    sb_t e;
    sb_t got;
    predict(a, e);
    bus.instr_addr_i = a;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    if (got.cb) check($sformatf("rd_big@%h", got.addr), bus.instr_rdata_o, got.eb);
    if (got.cs) check($sformatf("rd_small@%h", got.addr), sbus.instr_rdata_o, got.es);
    check($sformatf("rvalid@%h", got.addr), 32'(bus.instr_rvalid_o), 32'h1);
    $display("fetch addr=%h big=%h small=%h rvalid=%0b", got.addr, bus.instr_rdata_o,
             sbus.instr_rdata_o, bus.instr_rvalid_o);
  endtask

  // Streams img with load_valid_i held high throughout, then checks the session.
  task automatic load_image(input string tag);
    int n;
    int words;
    int wr_seen;
    int guard;
    bit acc;
    logic [31:0] w;
    n = img.size();
    words = (n + 3) / 4;
    wr_seen = 0;
    for (int wi = 0; wi < words; wi++) begin
      w = 32'h0;
      for (int b = 0; b < 4; b++)
        if (wi * 4 + b < n) w[b*8 +: 8] = img[wi * 4 + b];
      if (wi < BIG)   begin m_big[wi] = w;   k_big[wi] = 1'b1;   end
      if (wi < SMALL) begin m_small[wi] = w; k_small[wi] = 1'b1; end
    end
    for (int i = 0; i < n; i++) begin
      bus.load_valid_i = 1'b1;
      bus.load_data_i  = img[i];
      bus.load_last_i  = (i == n - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = bus.load_ready_o;
        if (!acc && bus.load_busy_o) wr_seen++;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 20);
      if (!acc) check({tag, "_accept_timeout"}, 32'(acc), 32'h1);
    end
    bus.load_valid_i = 1'b0;
    bus.load_last_i  = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      if (bus.load_busy_o && !bus.load_ready_o) wr_seen++;
      guard++;
    end while (bus.load_busy_o && guard < 20);
    check({tag, "_busy_fall"}, 32'(bus.load_busy_o), 32'h0);
    check({tag, "_rvalid_lag"}, 32'(bus.instr_rvalid_o), 32'h0);
    check({tag, "_write_cycles"}, 32'(wr_seen), 32'(words));
    check({tag, "_count_big"}, 32'(bus.load_count_o), 32'(words < BIG ? words : BIG));
    check({tag, "_err_big"}, 32'(bus.load_err_o), 32'(words > BIG));
    check({tag, "_count_small"}, 32'(sbus.load_count_o), 32'(words < SMALL ? words : SMALL));
    check({tag, "_err_small"}, 32'(sbus.load_err_o), 32'(words > SMALL));
    @(posedge clk);
    #1;
    check({tag, "_rvalid_rise"}, 32'(bus.instr_rvalid_o), 32'h1);
    $display("load %s: bytes=%0d words=%0d count=%0d/%0d err=%0b/%0b", tag, n, words,
             bus.load_count_o, sbus.load_count_o, bus.load_err_o, sbus.load_err_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_addr_i = 32'h0;
    bus.load_valid_i = 1'b0;
    bus.load_data_i  = 8'h0;
    bus.load_last_i  = 1'b0;

    #1 rst_n = 1'b0;
    #2 check_reset("power_on");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two full words.
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'hA0, 8'h00};
    load_image("two_words");
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    #2 rst_n = 1'b0;
    #1 check_reset("async_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Partial final word is zero-padded.
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_image("partial");
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);

    // 20 bytes overflow the 4-word instance only.
    img.delete();
    for (int i = 0; i < 20; i++) img.push_back(8'(8'h40 + i));
    load_image("overflow");
    fetch(32'h0000_0000);
    fetch(32'h0000_000C);
    fetch(32'h0000_0010);

    // A new session clears the sticky error.
    img = '{8'h5A};
    load_image("new_session");

    // Back-to-back fetches, out-of-range and unaligned addresses.
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_1000);
    fetch(32'h0000_0006);

    // Reset after two accepted bytes: nothing written, session dropped.
    bus.load_valid_i = 1'b1;
    bus.load_data_i  = 8'hEE;
    bus.load_last_i  = 1'b0;
    @(posedge clk);
    #1;
    bus.load_data_i  = 8'hDD;
    @(posedge clk);
    #1;
    check("mid_session_busy", 32'(bus.load_busy_o), 32'h1);
    bus.load_valid_i = 1'b0;
    rst_n = 1'b0;
    #1 check_reset("mid_session");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/triumph_imem.md
# triumph_imem

Instruction-memory responder for the Triumph core: it answers the fetch stage's address request with a registered 32-bit instruction word. It also contains a byte-stream loader that fills the array little-endian from word 0 upward, so the core can be held in reset while a program image is loaded. It sits outside `triumph_core`, driven by `instr_addr_o` and returning `instr_rdata_i`.

## Interface

**Parameters**
- `MEM_WORDS`, default 1024. Number of 32-bit words; must be a power of two, at least 4.
- `NOP_WORD`, default 32'h0000_0013. Word returned for out-of-range fetches (`addi x0,x0,0`).

**Ports**
- `clk_i`  in  1  Clock, rising edge.
- `rst_i`  in  1  Reset, asynchronous, active-low.
- `instr_addr_i`  in  32  Byte fetch address from the core.
- `instr_rdata_o`  out  32  Registered instruction word.
- `instr_rvalid_o`  out  1  `instr_rdata_o` is from a read taken while the loader was idle.
- `load_valid_i`  in  1  Loader byte valid.
- `load_ready_o`  out  1  Loader byte accepted when `load_valid_i && load_ready_o`.
- `load_data_i`  in  8  Loader byte.
- `load_last_i`  in  1  Marks the final byte of the image; qualified by the handshake.
- `load_busy_o`  out  1  A load session is in progress.
- `load_err_o`  out  1  Sticky: the image exceeded `MEM_WORDS`. Cleared when the next session starts.
- `load_count_o`  out  $clog2(MEM_WORDS)+1  Words written in the current or last session.

## Operation

**Read path**
- Word index = `instr_addr_i[$clog2(MEM_WORDS)+1:2]`.
- `instr_addr_i[1:0]` is ignored.
- Any nonzero bit of `instr_addr_i` above the index is out of range and returns `NOP_WORD`.
- Every cycle, `instr_rdata_o <= mem[idx]`, or `NOP_WORD` when out of range.
- `instr_rvalid_o <= (state == IDLE)`, registered alongside the data.

**Loader FSM.** Internal state: byte counter `cnt` (2 bits), 32-bit assembly buffer `buf`, word pointer `ptr` (saturates at `MEM_WORDS`), and a `last_seen` flag.
- **IDLE**
  - `load_ready_o = 1`.
  - On an accepted byte: it starts a session. `buf = {24'b0, byte}`, `cnt = 1`, `ptr = 0`, `load_count_o = 0`, `load_err_o = 0`, `last_seen = load_last_i`.
  - Next state is WRITE if `load_last_i` is high, otherwise FILL.
- **FILL**
  - `load_ready_o = 1`.
  - On an accepted byte: it goes into byte lane `cnt` of `buf`, `cnt++`, `last_seen = load_last_i`.
  - Go to WRITE when the accepted byte is lane 3 or `load_last_i` is high.
- **WRITE** (exactly 1 cycle)
  - `load_ready_o = 0`.
  - If `ptr < MEM_WORDS`: `mem[ptr] <= buf` and `load_count_o++`. Otherwise `load_err_o <= 1` and nothing is written (no wrap).
  - `ptr++` (saturating), `buf = 0`, `cnt = 0`.
  - Next state is IDLE if `last_seen`, otherwise FILL.
- `load_busy_o = (state != IDLE)`.
- A partial final word has its unfilled lanes written as zero; this is not an error.

**Boundary conditions**
- Write and read to the same word in the same cycle: the read returns the old contents.
- Reset mid-session: the FSM returns to IDLE, the partially assembled word is discarded, and words already written stay.
- The array itself is never reset.

## Timing

- Reset values: `instr_rdata_o = 0`, `instr_rvalid_o = 0`, `load_ready_o = 1`, `load_busy_o = 0`, `load_err_o = 0`, `load_count_o = 0`. FSM is IDLE, `ptr = 0`, `cnt = 0`.
- Read latency is 1 cycle. The address sampled at edge k appears on `instr_rdata_o` after edge k. Fully pipelined, one read per cycle.
- Loader throughput is 4 bytes per 5 cycles.
- A word written in WRITE at edge k is readable by an address presented in the cycle after edge k.
- `load_busy_o` falls at the edge that ends the final WRITE. `instr_rvalid_o` rises one edge later.
- A byte held valid through WRITE is accepted on the first FILL cycle, so no byte is lost or duplicated.

## Test plan

1. Reset: assert `rst_i` low mid-cycle -> all outputs immediately at their reset values, independent of the clock.
2. Load bytes `13 00 00 00 B3 00 A0 00`, with last on the 8th -> `mem[0] = 0000_0013`, `mem[1] = 00A0_00B3`, `load_count_o = 2`, `load_err_o = 0`. Then fetch address `0x4` -> next cycle `instr_rdata_o = 00A0_00B3` and `instr_rvalid_o = 1`.
3. Partial word: load bytes `11 22 33 44 55`, with last on `55` -> `mem[0] = 4433_2211`, `mem[1] = 0000_0055`, `load_count_o = 2`, `load_err_o = 0`.
4. Overflow with `MEM_WORDS = 4`: load 20 bytes -> words 0–3 written, `load_count_o = 4`, `load_err_o = 1`, `mem[0]` unchanged by the 5th word. Starting a new session clears `load_err_o`.
5. Reads at default size: back-to-back addresses `0x0, 0x4, 0x8` -> data follows with a 1-cycle lag. Address `0x0000_1000` -> `0000_0013`. Address `0x6` -> `mem[1]`.
6. Reset after 2 bytes of a session -> IDLE, no write, `load_count_o = 0`. Also: hold `load_valid_i` high continuously through a load -> `load_ready_o` is 0 during each WRITE and every byte is stored exactly once.
